// File: rtl/shift_chain_ctrl_pkg.sv
// Shared types and width helpers for the shift chain sequencer.
// Imported by the interface, the stage chain and the controller.
package shift_chain_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Counter must hold the value DEPTH itself, hence the extra bit.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/shift_chain_ctrl_if.sv
// Command, serial data and chain readout bundle between host and sequencer.
// The master drives commands and serial data; the slave (controller) drives status.
interface shift_chain_ctrl_if
  import shift_chain_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = cnt_width(DEPTH)
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [CNT_W-1:0] cmd_len;
  logic             hold;
  logic             din;
  logic             shift_en;
  logic             dout;
  logic [DEPTH-1:0] par_q;
  logic             busy;
  logic             done;

  modport master (
    output cmd_valid, cmd_len, hold, din,
    input  cmd_ready, shift_en, dout, par_q, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_len, hold, din,
    output cmd_ready, shift_en, dout, par_q, busy, done
  );
endinterface

// File: rtl/shift_chain_ctrl_chain.sv
// DEPTH-stage serial-in/parallel-out register chain; one stage per enabled edge,
// stage 0 takes din. Synchronous clear; holds its contents while en is low.
module shift_stage_chain #(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [DEPTH-1:0] q
);

  logic [DEPTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= {r_q[DEPTH-2:0], din};
    end
  end

  assign q = r_q;

endmodule

// File: rtl/shift_chain_ctrl.sv
// Sequences exactly len (clamped to DEPTH) chain shifts per accepted command, then pulses done.
// Latency len+1 cycles accept-to-done (plus held cycles); cmd_ready low while busy, hold stalls shifting.
module shift_chain_ctrl
  import shift_chain_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = cnt_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  shift_chain_ctrl_if.slave bus
);

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_len;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_len_clamp;
  logic             w_shift_en;
  logic             w_last_shift;
  logic [DEPTH-1:0] w_chain;

  assign w_len_clamp  = (bus.cmd_len > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : bus.cmd_len;
  assign w_shift_en   = (r_state == ST_SHIFT) && !bus.hold;
  assign w_last_shift = w_shift_en && (r_cnt == (r_len - CNT_W'(1)));

  // Status outputs are registered alongside the state so they never glitch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_len   <= '0;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_len   <= w_len_clamp;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (w_len_clamp == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          if (w_shift_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
          if (w_last_shift) begin
            r_state <= ST_DONE;
            r_done  <= 1'b1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  shift_stage_chain #(
    .DEPTH (DEPTH)
  ) u_chain (
    .clk (clk),
    .rst (rst),
    .en  (w_shift_en),
    .din (bus.din),
    .q   (w_chain)
  );

  assign bus.cmd_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.shift_en  = w_shift_en;
  assign bus.par_q     = w_chain;
  assign bus.dout      = w_chain[DEPTH-1];

endmodule

// File: tb/tb_shift_chain_ctrl.sv
// Directed scenarios followed by random traffic, all checked every cycle against a
// transaction-level model (remaining-shift count plus chain word).
module tb_shift_chain_ctrl;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  shift_chain_ctrl_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  shift_chain_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int sh_cnt      = 0;
  int done_cnt    = 0;

  // Reference model: a command becomes "m_rem shifts left", then one done cycle.
  bit             m_ok   = 1'b0;
  bit             m_act  = 1'b0;
  bit             m_done = 1'b0;
  int             m_rem  = 0;
  int             m_len  = 0;
  logic [DEPTH-1:0] m_chain = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1'b1; m_act = 1'b0; m_done = 1'b0; m_rem = 0; m_chain = '0;
    end else if (m_ok) begin
      if (m_done) begin
        m_done = 1'b0;
      end else if (m_act) begin
        if (!bus.hold) begin
          m_chain = {m_chain[DEPTH-2:0], bus.din};
          m_rem--;
          if (m_rem == 0) begin
            m_act = 1'b0; m_done = 1'b1;
          end
        end
      end else if (bus.cmd_valid) begin
        m_len = (int'(bus.cmd_len) > DEPTH) ? DEPTH : int'(bus.cmd_len);
        if (m_len == 0) m_done = 1'b1;
        else begin m_act = 1'b1; m_rem = m_len; end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("cmd_ready", 32'(bus.cmd_ready), 32'(!m_act && !m_done));
      chk("busy",      32'(bus.busy),      32'(m_act || m_done));
      chk("shift_en",  32'(bus.shift_en),  32'(m_act && !bus.hold));
      chk("done",      32'(bus.done),      32'(m_done));
      chk("par_q",     32'(bus.par_q),     32'(m_chain));
      chk("dout",      32'(bus.dout),      32'(m_chain[DEPTH-1]));
    end
    sh_cnt   += int'(bus.shift_en === 1'b1);
    done_cnt += int'(bus.done === 1'b1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one command; nsh shift cycles with word MSB first, optional 2-cycle hold before shift hold_at.
  task automatic run_cmd(input int len, input logic [15:0] word, input int nsh,
                         input int hold_at, input bit poke);
    bus.cmd_valid = 1'b1;
    bus.cmd_len   = CNT_W'(len);
    step();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < nsh; i++) begin
      if (i == hold_at) begin
        bus.hold = 1'b1;
        step();
        step();
        bus.hold = 1'b0;
      end
      bus.cmd_valid = poke && (i == 2);
      bus.din       = word[nsh-1-i];
      step();
    end
    bus.cmd_valid = 1'b0;
  endtask

  logic [DEPTH-1:0] nohold_q;

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_len   = '0;
    bus.hold      = 1'b0;
    bus.din       = 1'b0;

    // 1: reset with a pending command and din=1
    rst = 1'b1; bus.cmd_valid = 1'b1; bus.din = 1'b1; bus.cmd_len = CNT_W'(3);
    step(); step();
    rst = 1'b0; bus.cmd_valid = 1'b0; bus.din = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_par_q", 32'(bus.par_q),     32'h00);
    chk("rst_done",  32'(bus.done),      32'd0);

    // 2: three shifts of 1,0,1
    sh_cnt = 0; done_cnt = 0;
    run_cmd(3, 16'b101, 3, -1, 1'b0);
    @(negedge clk);
    chk("t2_shifts", 32'(sh_cnt),    32'd3);
    chk("t2_done",   32'(bus.done),  32'd1);
    chk("t2_par_q",  32'(bus.par_q), 32'h05);
    step();
    @(negedge clk);
    chk("t2_ready",  32'(bus.cmd_ready), 32'd1);
    chk("t2_ndone",  32'(done_cnt),      32'd1);

    // 3: full word A5 with an ignored command during SHIFT
    done_cnt = 0;
    run_cmd(8, 16'hA5, 8, -1, 1'b1);
    @(negedge clk);
    chk("t3_par_q", 32'(bus.par_q), 32'hA5);
    chk("t3_dout",  32'(bus.dout),  32'd1);
    step(); step(); step();
    chk("t3_ndone", 32'(done_cnt), 32'd1);

    // 4: four shifts without hold, then with a 2-cycle hold after the second shift
    run_cmd(4, 16'hB, 4, -1, 1'b0);
    @(negedge clk);
    nohold_q = bus.par_q;
    step();
    sh_cnt = 0;
    run_cmd(4, 16'hB, 4, 2, 1'b0);
    @(negedge clk);
    chk("t4_done",   32'(bus.done),        32'd1);
    chk("t4_shifts", 32'(sh_cnt),          32'd4);
    chk("t4_nibble", 32'(bus.par_q[3:0]),  32'(nohold_q[3:0]));
    chk("t4_par_q",  32'(bus.par_q),       32'hBB);
    step();

    // 5: zero-length command, then clamp of 12 to 8
    sh_cnt = 0;
    run_cmd(0, 16'h0, 0, -1, 1'b0);
    @(negedge clk);
    chk("t5_done0",  32'(bus.done),  32'd1);
    chk("t5_shift0", 32'(sh_cnt),    32'd0);
    chk("t5_par_q0", 32'(bus.par_q), 32'hBB);
    step();
    sh_cnt = 0;
    run_cmd(12, 16'h3C, 8, -1, 1'b0);
    @(negedge clk);
    chk("t5_done12",  32'(bus.done),  32'd1);
    chk("t5_shift12", 32'(sh_cnt),    32'd8);
    chk("t5_par_q12", 32'(bus.par_q), 32'h3C);
    step();

    // 6: reset on the third shift of a 6-shift command
    done_cnt = 0;
    bus.cmd_valid = 1'b1; bus.cmd_len = CNT_W'(6);
    step();
    bus.cmd_valid = 1'b0;
    bus.din = 1'b1; step();
    bus.din = 1'b1; step();
    rst = 1'b1; step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_par_q", 32'(bus.par_q),     32'h00);
    chk("t6_ready", 32'(bus.cmd_ready), 32'd1);
    chk("t6_busy",  32'(bus.busy),      32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("t6_ndone", 32'(done_cnt), 32'd0);

    // Random traffic, checked by the per-cycle compare process
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 79) == 0);
      bus.cmd_valid = $urandom_range(0, 1) == 1;
      bus.cmd_len   = CNT_W'($urandom_range(0, 15));
      bus.hold      = ($urandom_range(0, 3) == 0);
      bus.din       = $urandom_range(0, 1) == 1;
      step();
    end
    rst = 1'b0; bus.cmd_valid = 1'b0; bus.hold = 1'b0;
    for (int i = 0; i < 12; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_chain_ctrl.md
Name: shift_chain_ctrl

Overview:
Sequencer for a DEPTH-stage serial shift chain built from non-blocking register stages.
- Accepts a shift command (bit count) over a valid/ready handshake.
- Drives the chain for exactly that many enabled shift cycles, supports pause via hold, then signals completion with a one-cycle done pulse.
- Sits between a host/command source and serial capture logic. The parallel chain contents are exposed for readout.

Parameters:
DEPTH, 8, number of register stages in the chain (>=2)
CNT_W, $clog2(DEPTH)+1, width of cmd_len and internal shift counter

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
cmd_valid  input  1  command request
cmd_ready  output  1  controller can accept a command
cmd_len  input  CNT_W  number of shifts requested; sampled on handshake
hold  input  1  pause shifting while high (SHIFT state only)
din  input  1  serial data in, sampled into stage 0 on each shift edge
shift_en  output  1  high in cycles where the chain shifts at the next edge
dout  output  1  last stage, chain[DEPTH-1]
par_q  output  DEPTH  full chain contents, chain[DEPTH-1:0]
busy  output  1  high when state != IDLE
done  output  1  one-cycle completion pulse

Behaviour:
Reset:
- rst sampled high at an edge: state=IDLE, chain=0, counter=0, latched length=0, done=0.
- Therefore cmd_ready=1, busy=0, shift_en=0, dout=0, par_q=0 after reset.
- rst overrides every other input, including mid-SHIFT. Any in-flight command is dropped and no done is issued.

State machine (IDLE, SHIFT, DONE):
- IDLE:
  - cmd_ready=1.
  - On an edge with cmd_valid=1, the command is accepted and len_q=min(cmd_len, DEPTH).
  - If len_q==0, next state is DONE and the chain is untouched.
  - Otherwise counter=0 and next state is SHIFT.
- SHIFT:
  - cmd_ready=0.
  - shift_en = !hold (combinational).
  - On each edge with shift_en=1: chain[0]<=din, chain[i]<=chain[i-1], counter+1.
  - The edge where counter==len_q-1 with shift_en=1 is the final shift; next state is DONE.
  - hold=1: chain and counter frozen, state stays SHIFT.
- DONE:
  - done=1 for exactly this cycle; cmd_ready=0.
  - Next state is IDLE unconditionally.

Chain hold:
- Outside SHIFT, the chain holds its value, so par_q stays stable from DONE until the next command's first shift.

Timing:
- Accept at edge E0; shifts at edges E1..E(len).
- done is high in the cycle after E(len). The next accept is possible at edge E(len+2).
- Throughput is one command per len+2 cycles when hold=0.
- len=0: done is high in the cycle after E0.

Boundary conditions:
- cmd_len>DEPTH: clamped to DEPTH.
- cmd_valid while busy: ignored; no queuing.
- hold in IDLE or DONE: no effect.
- MSB-first serial input: after DEPTH shifts, par_q equals the transmitted word.

Decomposition:
- Package shift_chain_pkg:
  - state enum {ST_IDLE, ST_SHIFT, ST_DONE}, 2-bit encoding
  - CNT_W derivation helper
- Sub-module shift_stage_chain:
  - DEPTH-stage non-blocking shift register with ports clk, rst, en, din, q[DEPTH-1:0].
  - Synchronous clear.
- shift_chain_ctrl: FSM, counter and handshake, instantiating one shift_stage_chain.

Test Plan:
1. Reset: hold rst=1 for 2 cycles with cmd_valid=1 and din=1 -> after release cmd_ready=1, busy=0, par_q=8'h00, done=0. No command is accepted during reset.
2. DEPTH=8, cmd_len=3, din=1,0,1 on shift cycles -> exactly 3 shift_en cycles, par_q=8'b0000_0101, done high one cycle 4 edges after accept, then cmd_ready=1.
3. cmd_len=8, din=8'hA5 MSB first -> par_q=8'hA5, dout=1, done one cycle. A cmd_valid pulse during SHIFT is ignored (cmd_ready=0), so done occurs only once.
4. cmd_len=4 with hold=1 for 2 cycles after the second shift -> shift_en low for those 2 cycles, done delayed by exactly 2 cycles, par_q identical to the no-hold run.
5. cmd_len=0 -> no shift_en, done in the cycle after accept, par_q unchanged. cmd_len=12 -> exactly 8 shifts (clamp).
6. rst=1 during the 3rd shift of cmd_len=6 -> next cycle state IDLE, par_q=0, cmd_ready=1, no done pulse ever emitted for that command.
